// File: rtl/chu_led_seq_pkg.sv
// Shared types and register map for the LED pattern sequencer slot core.
package chu_led_seq_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [4:0] ADDR_CTRL      = 5'd0;
    localparam logic [4:0] ADDR_NSTEPS    = 5'd1;
    localparam logic [4:0] ADDR_IDLE_PAT  = 5'd2;
    localparam logic [4:0] ADDR_STEP_BASE = 5'd16;

    localparam int CTRL_START = 0;
    localparam int CTRL_STOP  = 1;
    localparam int CTRL_LOOP  = 2;

    function automatic logic [4:0] clamp_nsteps(input logic [4:0] v, input int unsigned max_n);
        return (32'(v) > max_n) ? 5'(max_n) : v;
    endfunction

endpackage

// File: rtl/led_ms_tick.sv
// Millisecond prescaler: counts 0..CLK_FREQ_KHZ-1 while enabled and pulses tick on wrap.
module led_ms_tick #(
    parameter int CLK_FREQ_KHZ = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLK_FREQ_KHZ > 1) ? $clog2(CLK_FREQ_KHZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_FREQ_KHZ - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/chu_led_seq.sv
// MMIO slot core that plays a table of (LED mask, duration in ms) steps once or in a loop.
module chu_led_seq
    import chu_led_seq_pkg::*;
#(
    parameter int W            = 8,
    parameter int N_STEPS      = 8,
    parameter int CLK_FREQ_KHZ = 100000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cs,
    input  logic         read,
    input  logic         write,
    input  logic [4:0]   addr,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data,
    output logic [W-1:0] dout
);

    localparam int IW = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t          state, state_nxt;
    logic            loop_en, done, done_nxt;
    logic [4:0]      nsteps;
    logic [W-1:0]    idle_pat, idle_pat_nxt;
    logic [W-1:0]    pat_tab [N_STEPS];
    logic [15:0]     dur_tab [N_STEPS];
    logic [W-1:0]    cur_pat, cur_pat_nxt;
    logic [15:0]     cur_dur, cur_dur_nxt, dur_eff;
    logic [15:0]     ms_cnt, ms_cnt_nxt;
    logic [IW-1:0]   idx, idx_nxt, idx_inc, step_sel;
    logic [7:0]      loop_cnt, loop_cnt_nxt;
    logic            wr_en, ctrl_wr, start_req, stop_req, is_step;
    logic            tick, step_end;
    logic            unused_bits;

    assign wr_en     = cs & write;
    assign ctrl_wr   = wr_en && (addr == ADDR_CTRL);
    assign stop_req  = ctrl_wr && wr_data[CTRL_STOP];
    // STOP wins over START; an empty table never starts
    assign start_req = ctrl_wr && wr_data[CTRL_START] && !wr_data[CTRL_STOP] && (nsteps != 5'd0);
    assign is_step   = addr[4] && ({1'b0, addr[3:0]} < 5'(N_STEPS));
    assign step_sel  = addr[IW-1:0];
    assign idx_inc   = idx + 1'b1;

    assign idle_pat_nxt = (wr_en && (addr == ADDR_IDLE_PAT)) ? wr_data[W-1:0] : idle_pat;

    led_ms_tick #(.CLK_FREQ_KHZ(CLK_FREQ_KHZ)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (start_req || (state == ST_IDLE)),
        .en    (state == ST_RUN),
        .tick  (tick)
    );

    assign dur_eff  = (cur_dur == 16'd0) ? 16'd1 : cur_dur;
    assign step_end = tick && (({1'b0, ms_cnt} + 17'd1) >= {1'b0, dur_eff});

    always_comb begin
        state_nxt    = state;
        done_nxt     = done;
        idx_nxt      = idx;
        loop_cnt_nxt = loop_cnt;
        cur_pat_nxt  = cur_pat;
        cur_dur_nxt  = cur_dur;
        ms_cnt_nxt   = ms_cnt;
        if ((state == ST_RUN) && stop_req) begin
            state_nxt  = ST_IDLE;
            ms_cnt_nxt = '0;
        end else if (start_req) begin
            state_nxt    = ST_RUN;
            done_nxt     = 1'b0;
            idx_nxt      = '0;
            loop_cnt_nxt = '0;
            cur_pat_nxt  = pat_tab[0];
            cur_dur_nxt  = dur_tab[0];
            ms_cnt_nxt   = '0;
        end else if ((state == ST_RUN) && step_end) begin
            ms_cnt_nxt = '0;
            // NSTEPS is re-read here so a shrink below idx+1 ends or wraps cleanly
            if ((5'(idx) + 5'd1) < nsteps) begin
                idx_nxt     = idx_inc;
                cur_pat_nxt = pat_tab[idx_inc];
                cur_dur_nxt = dur_tab[idx_inc];
            end else if (loop_en) begin
                idx_nxt      = '0;
                loop_cnt_nxt = sat_inc8(loop_cnt);
                cur_pat_nxt  = pat_tab[0];
                cur_dur_nxt  = dur_tab[0];
            end else begin
                state_nxt = ST_IDLE;
                done_nxt  = 1'b1;
            end
        end else if ((state == ST_RUN) && tick) begin
            ms_cnt_nxt = ms_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            done     <= 1'b0;
            idx      <= '0;
            loop_cnt <= '0;
            cur_pat  <= '0;
            cur_dur  <= '0;
            ms_cnt   <= '0;
            dout     <= '0;
        end else begin
            state    <= state_nxt;
            done     <= done_nxt;
            idx      <= idx_nxt;
            loop_cnt <= loop_cnt_nxt;
            cur_pat  <= cur_pat_nxt;
            cur_dur  <= cur_dur_nxt;
            ms_cnt   <= ms_cnt_nxt;
            dout     <= (state_nxt == ST_RUN) ? cur_pat_nxt : idle_pat_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loop_en  <= 1'b0;
            nsteps   <= '0;
            idle_pat <= '0;
            for (int i = 0; i < N_STEPS; i++) begin
                pat_tab[i] <= '0;
                dur_tab[i] <= '0;
            end
        end else begin
            idle_pat <= idle_pat_nxt;
            if (ctrl_wr) begin
                loop_en <= wr_data[CTRL_LOOP];
            end
            if (wr_en && (addr == ADDR_NSTEPS)) begin
                nsteps <= clamp_nsteps(wr_data[4:0], N_STEPS);
            end
            if (wr_en && is_step) begin
                pat_tab[step_sel] <= wr_data[W-1:0];
                dur_tab[step_sel] <= wr_data[31:16];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (addr == ADDR_CTRL) begin
            rd_data = {15'd0, loop_en, loop_cnt, 4'(idx), 2'b00, done, (state == ST_RUN)};
        end else if (addr == ADDR_NSTEPS) begin
            rd_data[4:0] = nsteps;
        end else if (addr == ADDR_IDLE_PAT) begin
            rd_data[W-1:0] = idle_pat;
        end else if (is_step) begin
            rd_data = {dur_tab[step_sel], 16'(pat_tab[step_sel])};
        end
    end

    // Reads have no side effects, so the read strobe is not needed
    assign unused_bits = ^{read, wr_data};

endmodule

// File: tb/tb_chu_led_seq.sv
// Self-checking bench for chu_led_seq: directed scenarios plus random bus traffic against a step-countdown model.
module tb_chu_led_seq;

    localparam int W = 8;
    localparam int N = 8;
    localparam int K = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cs = 1'b0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [4:0]    addr = '0;
    logic [31:0]   wr_data = '0;
    logic [31:0]   rd_data;
    logic [W-1:0]  dout;

    int checks = 0;
    int failures = 0;

    chu_led_seq #(.W(W), .N_STEPS(N), .CLK_FREQ_KHZ(K)) dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .dout    (dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: each step is a countdown of max(dur,1)*K cycles
    bit          m_run, m_done, m_loop_en;
    int          m_idx, m_loops, m_nsteps, m_rem;
    logic [7:0]  m_idle, m_pat, m_dout;
    logic [7:0]  tab_pat [N];
    logic [15:0] tab_dur [N];

    function automatic logic [31:0] m_read(input logic [4:0] a);
        int i;
        i = int'(a);
        if (i == 0) return {15'd0, m_loop_en, 8'(m_loops), 4'(m_idx), 2'b00, m_done, m_run};
        if (i == 1) return 32'(m_nsteps);
        if (i == 2) return 32'(m_idle);
        if (i >= 16 && i < 16 + N) return {tab_dur[i-16], 8'h00, tab_pat[i-16]};
        return 32'd0;
    endfunction

    task automatic model_reset();
        m_run = 0; m_done = 0; m_loop_en = 0;
        m_idx = 0; m_loops = 0; m_nsteps = 0; m_rem = 0;
        m_idle = 0; m_pat = 0; m_dout = 0;
        for (int i = 0; i < N; i++) begin
            tab_pat[i] = 0;
            tab_dur[i] = 0;
        end
    endtask

    task automatic model_load(input int i);
        m_pat = tab_pat[i];
        m_rem = ((tab_dur[i] == 16'd0) ? 1 : int'(tab_dur[i])) * K;
    endtask

    task automatic model_step();
        bit wr, st, sp;
        int a;
        wr = cs && write;
        a  = int'(addr);
        st = wr && (a == 0) && wr_data[0];
        sp = wr && (a == 0) && wr_data[1];
        if (m_run) begin
            if (sp) begin
                m_run = 0;
            end else if (st && m_nsteps != 0) begin
                m_done = 0; m_idx = 0; m_loops = 0; model_load(0);
            end else if (m_rem == 1) begin
                if (m_idx + 1 < m_nsteps) begin
                    m_idx++;
                    model_load(m_idx);
                end else if (m_loop_en) begin
                    m_idx = 0;
                    if (m_loops < 255) m_loops++;
                    model_load(0);
                end else begin
                    m_run = 0;
                    m_done = 1;
                end
            end else begin
                m_rem--;
            end
        end else if (st && !sp && m_nsteps != 0) begin
            m_run = 1; m_done = 0; m_idx = 0; m_loops = 0; model_load(0);
        end
        if (wr) begin
            if (a == 0) m_loop_en = wr_data[2];
            if (a == 1) m_nsteps = (int'(wr_data[4:0]) > N) ? N : int'(wr_data[4:0]);
            if (a == 2) m_idle = wr_data[7:0];
            if (a >= 16 && a < 16 + N) begin
                tab_pat[a-16] = wr_data[7:0];
                tab_dur[a-16] = wr_data[31:16];
            end
        end
        m_dout = m_run ? m_pat : m_idle;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    always @(negedge clk) begin
        #2;
        check("dout_cont", 32'(dout), 32'(m_dout));
        check("rd_cont", rd_data, m_read(addr));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        @(negedge clk);
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        cs = 1'b1; read = 1'b1; addr = a;
        #1;
        d = rd_data;
        cs = 1'b0; read = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(tag, d, exp);
    endtask

    initial begin
        logic [31:0] st;
        logic [7:0]  exp8;
        int          op;
        logic [4:0]  ra;

        cyc(2);
        reset = 1'b0;
        check("rst_dout", 32'(dout), 32'h00);
        rd_check("rst_status", 5'd0, 32'h0);
        rd_check("rst_step0", 5'd16, 32'h0);

        bus_wr(5'd2, 32'h0F);
        check("idle_pat_dout", 32'(dout), 32'h0F);

        // One-shot: 0x01 for 2 ms, 0x02 for 1 ms
        bus_wr(5'd16, {16'd2, 16'h01});
        bus_wr(5'd17, {16'd1, 16'h02});
        bus_wr(5'd1, 32'd2);
        bus_wr(5'd0, 32'h1);
        for (int c = 1; c <= 13; c++) begin
            exp8 = (c <= 8) ? 8'h01 : (c <= 12) ? 8'h02 : 8'h0F;
            check($sformatf("oneshot_t%0d", c), 32'(dout), 32'(exp8));
            cyc(1);
        end
        rd(5'd0, st);
        check("oneshot_done_busy", 32'(st[1:0]), 32'b10);

        // Loop: 12-cycle period, three wraps after 36 cycles
        bus_wr(5'd0, 32'h5);
        cyc(36);
        rd(5'd0, st);
        check("loop_cnt", 32'(st[15:8]), 32'd3);
        check("loop_idx", 32'(st[7:4]), 32'd0);
        check("loop_busy", 32'(st[1:0]), 32'b01);
        bus_wr(5'd0, 32'h2);
        check("stop_dout", 32'(dout), 32'h0F);
        rd(5'd0, st);
        check("stop_done_busy", 32'(st[1:0]), 32'b00);

        // Duration 0 behaves as 1 ms
        bus_wr(5'd16, {16'd0, 16'h33});
        bus_wr(5'd1, 32'd1);
        bus_wr(5'd0, 32'h1);
        check("dur0_t1", 32'(dout), 32'h33);
        cyc(3);
        check("dur0_t4", 32'(dout), 32'h33);
        cyc(1);
        check("dur0_t5", 32'(dout), 32'h0F);

        bus_wr(5'd1, 32'd12);
        rd_check("nsteps_clamp", 5'd1, 32'd8);

        bus_wr(5'd1, 32'd0);
        bus_wr(5'd0, 32'h1);
        rd(5'd0, st);
        check("start_ns0_busy", 32'(st[0]), 32'd0);

        // START|STOP together during RUN
        bus_wr(5'd16, {16'd2, 16'h01});
        bus_wr(5'd1, 32'd2);
        bus_wr(5'd0, 32'h1);
        cyc(2);
        bus_wr(5'd0, 32'h3);
        check("startstop_dout", 32'(dout), 32'h0F);
        rd(5'd0, st);
        check("startstop_busy", 32'(st[0]), 32'd0);

        // STEP0 rewritten mid-step takes effect at the next wrap
        bus_wr(5'd0, 32'h5);
        cyc(2);
        bus_wr(5'd16, {16'd2, 16'hAA});
        check("rewrite_cur", 32'(dout), 32'h01);
        cyc(8);
        check("rewrite_next", 32'(dout), 32'hAA);
        bus_wr(5'd0, 32'h2);

        // Async reset in the middle of step 1
        bus_wr(5'd16, {16'd2, 16'h01});
        bus_wr(5'd0, 32'h1);
        cyc(9);
        check("pre_reset_dout", 32'(dout), 32'h02);
        #1 reset = 1'b1;
        #1;
        check("areset_dout", 32'(dout), 32'h00);
        rd_check("areset_status", 5'd0, 32'h0);
        rd_check("areset_step1", 5'd17, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Random bus traffic
        for (int n = 0; n < 500; n++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2: bus_wr(5'(16 + $urandom_range(0, N - 1)),
                                {16'($urandom_range(0, 3)), 16'($urandom)});
                3:       bus_wr(5'd1, 32'($urandom_range(0, 31)));
                4:       bus_wr(5'd2, $urandom);
                5, 6:    bus_wr(5'd0, 32'($urandom_range(0, 7)));
                7: begin
                    ra = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(3, 15))
                                                     : 5'($urandom_range(24, 31));
                    bus_wr(ra, $urandom);
                end
                8: begin
                    ra = 5'($urandom_range(0, 31));
                    rd_check("rand_rd", ra, m_read(ra));
                end
                default: cyc($urandom_range(1, 16));
            endcase
            cyc($urandom_range(0, 3));
        end

        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
